// File: rtl/hpi_input_capture.sv
// hpi_input_capture: Avalon-MM input PIO for the HPI status lines.
// Synchronises asynchronous pins, latches edges into a sticky capture
// register and (optionally) raises a masked level interrupt.
// Optional feature macro: HPI_INPUT_CAPTURE_IRQ_EN (mask register + irq).
// Register map: 0 data (sync'd pins), 1 reads 0, 2 irq mask, 3 edge capture.
module hpi_input_capture #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SYNC_STAGES + 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] capture_q;
  logic [CNT_W-1:0] settle_cnt;

  logic             wr_en_c;
  logic             settle_done_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] mask_rd_c;

  assign sync_q        = sync_r[SYNC_STAGES-1];
  assign wr_en_c       = chipselect & ~write_n;
  assign settle_done_c = (settle_cnt == '0);

  // Bits of writedata beyond WIDTH carry no register state.
  if (WIDTH < 32) begin : g_wd_unused
    logic unused_writedata;
    assign unused_writedata = ^writedata[31:WIDTH];
  end

  // Multi-flop synchroniser for the asynchronous OTG pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Per-bit edge detect, suppressed until the synchroniser has refilled.
  always_comb begin
    edge_c = '0;
    case (EDGE_TYPE)
      0:       edge_c = sync_q & ~prev_q;
      1:       edge_c = ~sync_q & prev_q;
      default: edge_c = sync_q ^ prev_q;
    endcase
    if (!settle_done_c) edge_c = '0;
  end

  // Write-1-to-clear bits for the capture register.
  always_comb begin
    clr_c = '0;
    if (wr_en_c && (address == ADDR_CAPT)) clr_c = writedata[WIDTH-1:0];
  end

  // Settle counter, edge history and sticky capture; a new edge beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= SETTLE_LOAD;
      prev_q     <= '0;
      capture_q  <= '0;
    end else begin
      prev_q    <= sync_q;
      capture_q <= (capture_q & ~clr_c) | edge_c;
      if (!settle_done_c) settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

`ifdef HPI_INPUT_CAPTURE_IRQ_EN
  logic [WIDTH-1:0] mask_q;

  // Interrupt mask register and registered level interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en_c && (address == ADDR_MASK)) mask_q <= writedata[WIDTH-1:0];
      irq <= |(capture_q & mask_q);
    end
  end

  assign mask_rd_c = mask_q;
`else
  assign mask_rd_c = '0;
  assign irq       = 1'b0;
`endif

  // Zero-wait-state read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(sync_q);
      ADDR_MASK: readdata = 32'(mask_rd_c);
      ADDR_CAPT: readdata = 32'(capture_q);
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hpi_input_capture.sv
// tb_hpi_input_capture: directed bench for hpi_input_capture.
// u_rise uses defaults (rising edges); u_fall uses EDGE_TYPE=1.
module tb_hpi_input_capture;

`ifdef HPI_INPUT_CAPTURE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs0, cs1;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0, in1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hpi_input_capture u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0)
  );

  hpi_input_capture #(.EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1)
  );

  typedef struct {
    logic [3:0]  in_v;
    logic [31:0] exp_d;
    logic [31:0] exp_cap;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input bit which, input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    check(name, which ? rd1 : rd0, exp);
  endtask

  task automatic wr(input bit which, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs0       = ~which;
    cs1       = which;
    step();
    write_n   = 1'b1;
    cs0       = 1'b0;
    cs1       = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // in_port 0 -> 5 -> 0 on the rising-edge instance
    tbl[0] = '{4'h5, 32'h0, 32'h0};
    tbl[1] = '{4'h5, 32'h0, 32'h0};
    tbl[2] = '{4'h5, 32'h5, 32'h0};
    tbl[3] = '{4'h5, 32'h5, 32'h5};
    tbl[4] = '{4'h5, 32'h5, 32'h5};
    tbl[5] = '{4'h0, 32'h5, 32'h5};
    tbl[6] = '{4'h0, 32'h5, 32'h5};
    tbl[7] = '{4'h0, 32'h0, 32'h5};
    tbl[8] = '{4'h0, 32'h0, 32'h5};

    reset = 1'b1; cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in0 = 4'hF; in1 = 4'h0;
    step(); step();

    // Reset state
    rd(0, 2'd0, 32'h0, "reset_data");
    rd(0, 2'd3, 32'h0, "reset_cap");
    rd(0, 2'd2, 32'h0, "reset_mask");
    check("reset_irq", 32'(irq0), 32'h0);
    reset = 1'b0;

    // Lines held high through reset: data visible, no false capture
    for (int i = 0; i < 12; i++) begin
      rd(0, 2'd3, 32'h0, "held_high_cap");
      check("held_high_irq", 32'(irq0), 32'h0);
      if (i >= 2) rd(0, 2'd1, 32'h0, "addr1_zero");
      if (i >= 2) rd(0, 2'd0, 32'hF, "held_high_data");
      step();
    end

    in0 = 4'h0;
    repeat (4) step();
    rd(0, 2'd3, 32'h0, "fall_ignored_by_rise");

    // Table: synchroniser latency and capture latency
    for (int i = 0; i < 9; i++) begin
      in0 = tbl[i].in_v;
      rd(0, 2'd0, tbl[i].exp_d, "tbl_data");
      rd(0, 2'd3, tbl[i].exp_cap, "tbl_cap");
      check("tbl_irq", 32'(irq0), 32'h0);
      step();
    end

    wr(0, 2'd3, 32'hF);
    rd(0, 2'd3, 32'h0, "clear_all");

    // Mask, upper writedata bits ignored
    wr(0, 2'd2, 32'hFFFF_FFF1);
    rd(0, 2'd2, IRQ_ON ? 32'h1 : 32'h0, "mask_rb");

    // irq lags capture by one cycle
    in0 = 4'h1;
    for (int i = 0; i < 5; i++) begin
      rd(0, 2'd3, (i >= 3) ? 32'h1 : 32'h0, "irq_seq_cap");
      check("irq_seq_irq", 32'(irq0), (IRQ_ON && i >= 4) ? 32'h1 : 32'h0);
      step();
    end
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, 32'h0, "irq_clr_cap");
    check("irq_clr_lag", 32'(irq0), IRQ_ON ? 32'h1 : 32'h0);
    step();
    check("irq_clr_irq", 32'(irq0), 32'h0);

    // Clear and new edge on bit 2 in the same cycle: edge wins
    in0 = 4'h5;
    step(); step();
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, "edge_beats_clr");
    check("unmasked_irq", 32'(irq0), 32'h0);
    wr(0, 2'd3, 32'h0);
    rd(0, 2'd3, 32'h4, "write0_keeps");
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h0, "write1_clears");

    // Capture 4'hA, then ignored writes, then mid-run reset
    in0 = 4'hF;
    repeat (3) step();
    rd(0, 2'd3, 32'hA, "cap_A");
    wr(0, 2'd0, 32'hF);
    wr(0, 2'd1, 32'hF);
    rd(0, 2'd3, 32'hA, "ign_wr_cap");
    rd(0, 2'd2, IRQ_ON ? 32'h1 : 32'h0, "ign_wr_mask");
    rd(0, 2'd0, 32'hF, "ign_wr_data");
    rd(0, 2'd3, 32'hA, "read_no_clear");
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(0, 2'd3, 32'h0, "midrst_cap");
    rd(0, 2'd2, 32'h0, "midrst_mask");
    check("midrst_irq", 32'(irq0), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd(0, 2'd3, 32'h0, "midrst_settle_cap");
      step();
    end

    // Falling-edge instance: 4-cycle high pulse on bit 3
    in1 = 4'h8;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) in1 = 4'h0;
      rd(1, 2'd3, (i >= 7) ? 32'h8 : 32'h0, "fall_cap");
      rd(1, 2'd2, 32'h0, "fall_mask");
      check("fall_irq", 32'(irq1), 32'h0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
